// File: rtl/minv_host_ctrl_pkg.sv
// minv_host_ctrl_pkg: shared widths and FSM encoding for the
// modular-inverse host controller.
package minv_host_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int OPND_W = 256;
  localparam int WORDS  = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_P,
    GO,
    WAIT_RDY,
    GAP,
    UNLOAD,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/minv_word_shift.sv
// minv_word_shift: word-granular shift register, shifting toward bit 0
// and filling the top word; dout exposes the low OUT_W bits.
module minv_word_shift
  import minv_host_ctrl_pkg::*;
#(
  parameter int N     = WORDS,
  parameter int OUT_W = N * WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [N*WORD_W-1:0]   din,
  input  logic [WORD_W-1:0]     word,
  output logic [OUT_W-1:0]      dout
);

  logic [N*WORD_W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {word, q[N*WORD_W-1:WORD_W]};
    end
  end

  assign dout = q[OUT_W-1:0];

endmodule

// File: rtl/minv_host_ctrl.sv
// minv_host_ctrl: loads a and p into the inverse engine word by word,
// waits for completion, then unloads and captures x1/x2.
module minv_host_ctrl
  import minv_host_ctrl_pkg::*;
#(
  parameter int WORDS   = 16,
  parameter int RDY_GAP = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPND_W-1:0] a_in,
  input  logic [OPND_W-1:0] p_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OPND_W-1:0] x1_out,
  output logic [OPND_W-1:0] x2_out,
  output logic              flag_out,
  output logic [WORD_W-1:0] datain,
  output logic              loada,
  output logic              loadp,
  output logic              minv_en,
  output logic              outx1,
  output logic              outx2,
  input  logic [WORD_W-1:0] regx1out,
  input  logic [WORD_W-1:0] regx2out,
  input  logic              minv_rdy,
  input  logic              minv_flag
);

  state_t              state;
  state_t              nxt;
  logic [31:0]         cnt;
  logic                last;
  logic                op_load;
  logic                op_shift;
  logic                cap;
  logic [WORD_W-1:0]   op_word;
  logic [OPND_W-1:0]   x1_q;
  logic [OPND_W-1:0]   x2_q;

  assign last = (cnt == 32'(WORDS - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (start) nxt = LOAD_A;
      LOAD_A:   if (last) nxt = LOAD_P;
      LOAD_P:   if (last) nxt = GO;
      GO:       nxt = WAIT_RDY;
      WAIT_RDY: begin
        if (minv_rdy) begin
          nxt = (RDY_GAP == 0) ? UNLOAD : GAP;
        end else if (cnt == 32'(TIMEOUT - 1)) begin
          nxt = FIN;
        end
      end
      GAP:      if (cnt == 32'(RDY_GAP - 1)) nxt = UNLOAD;
      UNLOAD:   if (last) nxt = DRAIN;
      DRAIN:    nxt = FIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      flag_out <= 1'b0;
      x1_out   <= '0;
      x2_out   <= '0;
    end else begin
      state <= nxt;
      // every state measures its own dwell from zero
      cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 32'd1;
      if (state == IDLE && start) err <= 1'b0;
      if (state == WAIT_RDY) begin
        if (minv_rdy) flag_out <= minv_flag;
        else if (nxt == FIN) err <= 1'b1;
      end
      if (state == FIN && !err) begin
        x1_out <= x1_q;
        x2_out <= x2_q;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign loada   = (state == LOAD_A);
  assign loadp   = (state == LOAD_P);
  assign minv_en = (state == GO);
  assign outx1   = (state == UNLOAD);
  assign outx2   = (state == UNLOAD);
  assign datain  = (loada || loadp) ? op_word : '0;

  assign op_load  = (state == IDLE) && start;
  assign op_shift = loada || loadp;
  // read data trails the strobe by one cycle, so skip the first slot
  assign cap = ((state == UNLOAD) && (cnt != 0)) || (state == DRAIN);

  minv_word_shift #(.N(2 * WORDS), .OUT_W(WORD_W)) u_op (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (op_load),
    .shift (op_shift),
    .din   ({p_in, a_in}),
    .word  ('0),
    .dout  (op_word)
  );

  minv_word_shift #(.N(WORDS)) u_x1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b0),
    .shift (cap),
    .din   ('0),
    .word  (regx1out),
    .dout  (x1_q)
  );

  minv_word_shift #(.N(WORDS)) u_x2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b0),
    .shift (cap),
    .din   ('0),
    .word  (regx2out),
    .dout  (x2_q)
  );

endmodule

// File: doc/minv_host_ctrl.md
MINV_HOST_CTRL -- requirements
Module: minv_host_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 16, meaning number of 16-bit words per 256-bit operand.
REQ-002 SHALL have parameter RDY_GAP, default 2, meaning idle cycles between minv_rdy detection and the first outx1/outx2 cycle.
REQ-003 SHALL have parameter TIMEOUT, default 65535, meaning the maximum number of WAIT_RDY cycles before an error is declared.
REQ-004 Port: clk  input  1  single clock; all logic is rising-edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 Port: a_in, p_in  input  256 each  operand a and modulus p; held stable by the host while busy.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: done  output  1  one-cycle pulse when a job ends, whether it succeeded or failed.
REQ-010 Port: err  output  1  valid with done; high means the job timed out.
REQ-011 Port: x1_out, x2_out  output  256 each  captured results; hold their value until the next done.
REQ-012 Port: flag_out  output  1  minv_flag as sampled on the cycle minv_rdy was seen.
REQ-013 Port: datain  output  16  word bus to the engine.
REQ-014 Port: loada, loadp, minv_en, outx1, outx2  output  1 each  engine control strobes.
REQ-015 Port: regx1out, regx2out  input  16 each  engine result words.
REQ-016 Port: minv_rdy, minv_flag  input  1 each  engine completion status.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_A, LOAD_P, GO, WAIT_RDY, GAP, UNLOAD, DRAIN, FIN; exactly one state is active per cycle.
REQ-018 IDLE SHALL move to LOAD_A on start=1, latching a_in and p_in into internal 256-bit shift registers on the same edge.
REQ-019 LOAD_A SHALL last WORDS cycles with loada=1 and datain = a word k (k=0..15, least-significant word first, a[16k+15:16k]).
REQ-020 LOAD_P SHALL immediately follow LOAD_A for WORDS cycles with loadp=1 and datain = p word k, using the same order; loada and loadp SHALL never be high in the same cycle.
REQ-021 GO SHALL last 1 cycle with minv_en=1 and datain=0.
REQ-022 WAIT_RDY SHALL count cycles; on minv_rdy=1 it SHALL latch flag_out and move to GAP; if the count reaches TIMEOUT it SHALL move to FIN with err=1.
REQ-023 GAP SHALL last RDY_GAP cycles with all strobes low.
REQ-024 UNLOAD SHALL last WORDS cycles with outx1=outx2=1.
REQ-025 Engine read latency is 1: the regx1out/regx2out value in the cycle after the j-th UNLOAD cycle is result word j, least-significant word first.
REQ-026 DRAIN SHALL last 1 cycle with strobes low and SHALL capture the final word; capture SHALL happen in UNLOAD cycles 2..WORDS and in DRAIN, into 256-bit shift registers.
REQ-027 FIN SHALL last 1 cycle: it pulses done, copies the shift registers to x1_out/x2_out (only when err=0), and returns to IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 A minv_rdy pulse outside WAIT_RDY SHALL be ignored.
REQ-030 All strobes SHALL be low and datain=0 in IDLE, GAP, DRAIN and FIN.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously force state=IDLE, all strobes=0, datain=0, busy=0, done=0, err=0, flag_out=0, x1_out=0, x2_out=0, and counters=0.
REQ-032 Reset mid-job SHALL abort the job with no done pulse; the first start after rst_n rises SHALL begin a clean LOAD_A.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the constants WORD_W=16, OPND_W=256 and WORDS=16.
REQ-034 The word serializer/deserializer (a 256-bit shift register with a 16-bit tap) SHALL be one sub-module, minv_word_shift, instantiated three times: operand out, x1 in, x2 in.

Verification
REQ-035 a=5, p=11 -> datain 0x0005 then 15x 0x0000 under loada; 0x000B then 15x 0x0000 under loadp; minv_en high exactly on cycle 33 after start.
REQ-036 a=256'h7879...e498, p=256'h8542...dfc3, engine model returns a^-1 mod p -> x1_out equals the model value, done pulses once, err=0.
REQ-037 Engine model returns words 0x0001..0x0010 (word j = j+1) -> x1_out = 256'h0010_000F_..._0001 and the same for x2_out, confirming order and latency.
REQ-038 TIMEOUT=100 and minv_rdy never asserted -> done with err=1 at exactly WAIT_RDY cycle 100, x1_out unchanged, outx1 never asserted.
REQ-039 start re-pulsed during LOAD_P, plus a minv_rdy glitch during LOAD_A -> no restart, and the sequence still matches REQ-035.
REQ-040 rst_n dropped during UNLOAD cycle 5 -> all outputs reach their reset values without a clock edge, no done pulse, and the next job completes normally.
